// File: rtl/psg_pkg.sv
// psg_pkg: shared constants and types for the SN76489-compatible PSG.
//   CLK_DIV     default clk cycles per PSG tick
//   LFSR_SEED   value loaded into the noise shift register on reset / noise ctrl write
//   VOL_TBL     attenuation (0..15) to unsigned 14-bit amplitude, 15 is silent
//   NOISE_RATE  fixed noise counter reload values for ctrl[1:0] = 00/01/10
//   psg_ch_e    channel field of a latch byte
//   psg_type_e  register type field of a latch byte
package psg_pkg;

  localparam int unsigned CLK_DIV = 128;

  localparam logic [15:0] LFSR_SEED = 16'h8000;

  localparam logic [13:0] VOL_TBL [16] = '{
    14'd8191, 14'd6506, 14'd5168, 14'd4105,
    14'd3261, 14'd2590, 14'd2057, 14'd1634,
    14'd1298, 14'd1031, 14'd819,  14'd650,
    14'd516,  14'd410,  14'd326,  14'd0
  };

  localparam logic [9:0] NOISE_RATE [3] = '{10'h10, 10'h20, 10'h40};

  typedef enum logic [1:0] {
    CH_TONE0 = 2'd0,
    CH_TONE1 = 2'd1,
    CH_TONE2 = 2'd2,
    CH_NOISE = 2'd3
  } psg_ch_e;

  typedef enum logic {
    REG_TONE  = 1'b0,  // frequency for ch0-2, control for the noise channel
    REG_ATTEN = 1'b1
  } psg_type_e;

endpackage

// File: rtl/psg_tone_gen.sv
// psg_tone_gen: one square-wave tone channel.
//   clk, reset  system clock, asynchronous active-high reset
//   tick        one-clk PSG tick enable from the prescaler
//   freq        10-bit half-period in ticks
//   out         square output; held at 1 while freq is 0 or 1 (DC level used for PCM)
module psg_tone_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [9:0] freq,
  output logic       out
);

  logic [9:0] counter_q, counter_d;
  logic       ff_q, ff_d;

  // A frequency change is not pushed into the counter; it takes effect at the
  // next natural reload.
  always_comb begin
    counter_d = counter_q;
    ff_d      = ff_q;
    if (tick) begin
      if (counter_q <= 10'd1) begin
        counter_d = freq;
        ff_d      = ~ff_q;
      end else begin
        counter_d = counter_q - 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_q <= '0;
      ff_q      <= 1'b0;
    end else begin
      counter_q <= counter_d;
      ff_q      <= ff_d;
    end
  end

  // The flip-flop keeps running underneath; only the visible level is forced.
  assign out = (freq <= 10'd1) ? 1'b1 : ff_q;

endmodule

// File: rtl/sn76489_psg.sv
// sn76489_psg: SN76489-compatible PSG, 3 square tone channels + 1 LFSR noise
// channel, each with 4-bit attenuation, mixed into one signed 16-bit sample.
//   clk     system clock (28.63636 MHz)
//   reset   asynchronous, active-high
//   wrdata  register write byte (port $7F)
//   wren    write strobe: a byte is accepted on every clk edge where wren is
//           high, with wrdata valid in that same cycle; there is no back-pressure,
//           so one high cycle is exactly one write
//   sample  registered signed mix of all four channels
module sn76489_psg
  import psg_pkg::*;
#(
  parameter int unsigned CLK_DIV = psg_pkg::CLK_DIV
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         wrdata,
  input  logic               wren,
  output logic signed [15:0] sample
);

  localparam int PW = $clog2(CLK_DIV);

  // ---------------------------------------------------------------- prescaler
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  assign tick    = (presc_q == PW'(CLK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  // ------------------------------------------------------------ register file
  logic [9:0] freq_q  [3];
  logic [9:0] freq_d  [3];
  logic [3:0] atten_q [4];
  logic [3:0] atten_d [4];
  logic [2:0] nctrl_q, nctrl_d;
  psg_ch_e    latch_ch_q, latch_ch_d;
  psg_type_e  latch_type_q, latch_type_d;

  logic       is_latch;
  psg_ch_e    wr_ch;
  psg_type_e  wr_type;
  logic       noise_wr;

  // A latch byte selects its own target; a data byte goes to the last latched one.
  assign is_latch = wrdata[7];
  assign wr_ch    = is_latch ? psg_ch_e'(wrdata[6:5]) : latch_ch_q;
  assign wr_type  = is_latch ? psg_type_e'(wrdata[4]) : latch_type_q;

  always_comb begin
    for (int i = 0; i < 3; i++) freq_d[i] = freq_q[i];
    for (int i = 0; i < 4; i++) atten_d[i] = atten_q[i];
    nctrl_d      = nctrl_q;
    latch_ch_d   = latch_ch_q;
    latch_type_d = latch_type_q;
    noise_wr     = 1'b0;
    if (wren) begin
      if (is_latch) begin
        latch_ch_d   = wr_ch;
        latch_type_d = wr_type;
      end
      if (wr_type == REG_ATTEN) begin
        atten_d[wr_ch] = wrdata[3:0];
      end else if (wr_ch == CH_NOISE) begin
        nctrl_d  = wrdata[2:0];
        noise_wr = 1'b1;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (wr_ch == psg_ch_e'(2'(i))) begin
            if (is_latch) freq_d[i][3:0] = wrdata[3:0];
            else          freq_d[i][9:4] = wrdata[5:0];
          end
        end
      end
    end
  end

  // ------------------------------------------------------------ tone channels
  logic [3:0] chan_out;

  for (genvar g = 0; g < 3; g++) begin : g_tone
    psg_tone_gen u_tone (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .freq  (freq_q[g]),
      .out   (chan_out[g])
    );
  end

  // ------------------------------------------------------------ noise channel
  logic [9:0]  ncnt_q, ncnt_d;
  logic        nff_q, nff_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [9:0]  noise_reload;
  logic        lfsr_in;

  always_comb begin
    case (nctrl_q[1:0])
      2'b00:   noise_reload = NOISE_RATE[0];
      2'b01:   noise_reload = NOISE_RATE[1];
      2'b10:   noise_reload = NOISE_RATE[2];
      default: noise_reload = freq_q[2];
    endcase
  end

  // ctrl[2] selects white noise (taps 0,3) over periodic (pure rotation).
  assign lfsr_in = nctrl_q[2] ? (lfsr_q[0] ^ lfsr_q[3]) : lfsr_q[0];

  always_comb begin
    ncnt_d = ncnt_q;
    nff_d  = nff_q;
    lfsr_d = lfsr_q;
    if (tick) begin
      if (ncnt_q <= 10'd1) begin
        ncnt_d = noise_reload;
        nff_d  = ~nff_q;
        // The register advances only on the rising edge of the noise flip-flop.
        if (!nff_q) lfsr_d = {lfsr_in, lfsr_q[15:1]};
      end else begin
        ncnt_d = ncnt_q - 10'd1;
      end
    end
    // Rewriting the noise control always restarts the sequence, even on a shift cycle.
    if (noise_wr) lfsr_d = LFSR_SEED;
  end

  assign chan_out[3] = lfsr_q[0];

  // -------------------------------------------------------------------- mixer
  logic signed [15:0] mix_sum;
  logic signed [15:0] amp;

  always_comb begin
    mix_sum = '0;
    amp     = '0;
    for (int i = 0; i < 4; i++) begin
      amp     = signed'({2'b00, VOL_TBL[atten_q[i]]});
      mix_sum = chan_out[i] ? (mix_sum + amp) : (mix_sum - amp);
    end
  end

  logic signed [15:0] sample_q;

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q      <= '0;
      for (int i = 0; i < 3; i++) freq_q[i] <= '0;
      for (int i = 0; i < 4; i++) atten_q[i] <= 4'hF;
      nctrl_q      <= 3'b000;
      latch_ch_q   <= CH_TONE0;
      latch_type_q <= REG_TONE;
      ncnt_q       <= '0;
      nff_q        <= 1'b0;
      lfsr_q       <= LFSR_SEED;
      sample_q     <= '0;
    end else begin
      presc_q      <= presc_d;
      for (int i = 0; i < 3; i++) freq_q[i] <= freq_d[i];
      for (int i = 0; i < 4; i++) atten_q[i] <= atten_d[i];
      nctrl_q      <= nctrl_d;
      latch_ch_q   <= latch_ch_d;
      latch_type_q <= latch_type_d;
      ncnt_q       <= ncnt_d;
      nff_q        <= nff_d;
      lfsr_q       <= lfsr_d;
      sample_q     <= mix_sum;
    end
  end

  assign sample = sample_q;

endmodule

// File: tb/tb_sn76489_psg.sv
// tb_sn76489_psg: randomized bench for sn76489_psg against a behavioural model.
// The model keeps the programmer-visible PSG state as plain integers, advances
// it one clk at a time and queues the expected sample for comparison.
module tb_sn76489_psg;

  // ------------------------------------------------------- clock and reset
  logic               clk;
  logic               reset;
  logic [7:0]         wrdata;
  logic               wren;
  logic signed [15:0] sample;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  sn76489_psg dut (
    .clk    (clk),
    .reset  (reset),
    .wrdata (wrdata),
    .wren   (wren),
    .sample (sample)
  );

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for model condition at %0t", tag, $time);
  endtask

  // ------------------------------------------------------- reference model
  localparam int VOL [16] = '{8191, 6506, 5168, 4105, 3261, 2590, 2057, 1634,
                              1298, 1031, 819, 650, 516, 410, 326, 0};

  int m_presc, m_ctrl, m_lfsr, m_ch, m_type, m_ncnt, m_nff, m_shifts;
  int m_freq [3];
  int m_cnt  [3];
  int m_ff   [3];
  int m_atten[4];

  logic [15:0] exp_q[$];

  task automatic model_reset();
    m_presc = 0; m_ctrl = 0; m_lfsr = 32'h8000; m_ch = 0; m_type = 0;
    m_ncnt = 0; m_nff = 0; m_shifts = 0;
    for (int i = 0; i < 3; i++) begin m_freq[i] = 0; m_cnt[i] = 0; m_ff[i] = 0; end
    for (int i = 0; i < 4; i++) m_atten[i] = 15;
    exp_q.delete();
  endtask

  function automatic int model_mix();
    int sum = 0;
    int lvl;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) lvl = (m_freq[i] <= 1) ? 1 : m_ff[i];
      else       lvl = m_lfsr & 1;
      sum += lvl ? VOL[m_atten[i]] : -VOL[m_atten[i]];
    end
    return sum;
  endfunction

  task automatic model_tick();
    int reload, bit_in;
    for (int i = 0; i < 3; i++) begin
      if (m_cnt[i] <= 1) begin m_cnt[i] = m_freq[i]; m_ff[i] ^= 1; end
      else m_cnt[i]--;
    end
    reload = ((m_ctrl & 3) == 3) ? m_freq[2] : (16 << (m_ctrl & 3));
    if (m_ncnt <= 1) begin
      m_ncnt = reload;
      m_nff ^= 1;
      if (m_nff == 1) begin
        bit_in = (m_ctrl & 4) ? ((m_lfsr ^ (m_lfsr >> 3)) & 1) : (m_lfsr & 1);
        m_lfsr = (m_lfsr >> 1) | (bit_in << 15);
        m_shifts++;
      end
    end else m_ncnt--;
  endtask

  task automatic model_write(input int b);
    if (b & 128) begin m_ch = (b >> 5) & 3; m_type = (b >> 4) & 1; end
    if (m_type == 1)          m_atten[m_ch] = b & 15;
    else if (m_ch == 3)       begin m_ctrl = b & 7; m_lfsr = 32'h8000; m_shifts = 0; end
    else if (b & 128)         m_freq[m_ch] = (m_freq[m_ch] & 10'h3F0) | (b & 15);
    else                      m_freq[m_ch] = (m_freq[m_ch] & 15) | ((b & 63) << 4);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_reset();
    end else begin
      exp_q.push_back(16'(model_mix()));
      if (m_presc == 127) model_tick();
      m_presc = (m_presc + 1) % 128;
      if (wren) model_write(int'(wrdata));
    end
  end

  // Scoreboard: every clk, the registered sample must equal the model's mix.
  always @(negedge clk) begin
    if (!reset && exp_q.size() > 0) check_val("sample", sample, exp_q.pop_front());
  end

  // Independent LFSR sequence from the seed, taps 0 and 3 (white) or rotation.
  function automatic logic [15:0] lfsr_ref(input int n, input bit white);
    int l = 32'h8000;
    int b;
    for (int k = 0; k < n; k++) begin
      b = white ? ((l ^ (l >> 3)) & 1) : (l & 1);
      l = (l >> 1) | (b << 15);
    end
    return 16'(l);
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic wr(input logic [7:0] b);
    wrdata = b;
    wren   = 1'b1;
    @(negedge clk);
    wren   = 1'b0;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_shifts(input int k, input int bound);
    int guard = 0;
    while (m_shifts < k && guard < bound) begin @(negedge clk); guard++; end
    if (guard >= bound) timeout("noise_shifts");
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    bit seen_pos, seen_neg, steady;
    int guard;

    reset = 1'b1; wren = 1'b0; wrdata = '0;
    #23;
    check_val("reset_sample", sample, 16'd0);
    check_val("reset_lfsr", dut.lfsr_q, 16'h8000);
    check_val("reset_atten0", 16'(dut.atten_q[0]), 16'hF);
    @(negedge clk);
    reset = 1'b0;

    // Silent after reset for 10k clks.
    wait_clks(10000);
    check_val("idle_sample", sample, 16'd0);

    // ch0 freq=14, atten 0: square wave of +/-8191.
    wr(8'h8E); wr(8'h00); wr(8'h90);
    seen_pos = 0; seen_neg = 0;
    repeat (14 * 128 * 4) begin
      @(negedge clk);
      if (sample == 16'sd8191)  seen_pos = 1;
      if (sample == -16'sd8191) seen_neg = 1;
    end
    check_val("ch0_high_seen", 16'(seen_pos), 16'd1);
    check_val("ch0_low_seen", 16'(seen_neg), 16'd1);

    // ch0 freq=1 -> DC high; mute takes one clk to reach sample.
    wr(8'h81); wr(8'h00);
    check_val("ch0_freq1", dut.freq_q[0], 16'd1);
    wait_clks(4);
    steady = 1;
    repeat (300) begin
      @(negedge clk);
      if (sample != 16'sd8191) steady = 0;
    end
    check_val("ch0_dc_steady", 16'(steady), 16'd1);
    wr(8'h9F);
    check_val("mute_prev", sample, 16'd8191);
    @(negedge clk);
    check_val("mute_next", sample, 16'd0);

    // White noise at rate 00, noise atten 0.
    wr(8'hE4);
    check_val("noise_seed", dut.lfsr_q, 16'h8000);
    wr(8'hF0);
    wait_shifts(2, 16000);
    check_val("lfsr_rate00", dut.lfsr_q, lfsr_ref(2, 1'b1));

    // Fast clocking through tone2 (freq=1) to walk the first 64 shifts.
    wr(8'hC1); wr(8'h00);
    wr(8'hE7);
    for (int k = 8; k <= 64; k += 8) begin
      wait_shifts(k, 4000);
      check_val("lfsr_seq", dut.lfsr_q, lfsr_ref(k, 1'b1));
    end

    // Noise ctrl write on a tick that would also shift: the seed wins.
    guard = 0;
    while (!(m_presc == 127 && m_nff == 0 && m_ncnt <= 1) && guard < 2000) begin
      @(negedge clk); guard++;
    end
    if (guard >= 2000) timeout("tick_align");
    wr(8'hE7);
    check_val("tick_write_seed", dut.lfsr_q, 16'h8000);

    // Attenuation write landing on a tick.
    guard = 0;
    while (m_presc != 127 && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) timeout("tick_align_atten");
    wr(8'hF5);
    check_val("tick_write_atten", 16'(dut.atten_q[3]), 16'd5);
    wait_clks(3);

    // Full scale: all tones DC, all atten 0, periodic noise until lfsr[0]=1.
    wr(8'h81); wr(8'h00); wr(8'hA1); wr(8'h00);
    wr(8'h90); wr(8'hB0); wr(8'hD0); wr(8'hF0);
    wr(8'hE3);
    guard = 0;
    while ((m_lfsr & 1) == 0 && guard < 8000) begin @(negedge clk); guard++; end
    if (guard >= 8000) timeout("noise_high");
    @(negedge clk);
    check_val("full_scale", sample, 16'd32764);

    // Latch/data routing for ch2.
    wr(8'hC5); wr(8'h3F);
    check_val("ch2_freq", dut.freq_q[2], 16'h3F5);
    wr(8'hD0); wr(8'h15);
    check_val("ch2_atten", 16'(dut.atten_q[2]), 16'd5);
    check_val("ch2_freq_kept", dut.freq_q[2], 16'h3F5);

    // Random register traffic.
    for (int n = 0; n < 60; n++) begin
      wr(8'($urandom_range(0, 255)));
      wait_clks($urandom_range(0, 300));
    end

    // Reset in the middle of activity.
    wr(8'h81); wr(8'h00); wr(8'h90); wr(8'hBF); wr(8'hDF); wr(8'hFF);
    wait_clks(2);
    check_val("pre_reset", sample, 16'd8191);
    #2 reset = 1'b1;
    #1;
    check_val("mid_reset_sample", sample, 16'd0);
    check_val("mid_reset_lfsr", dut.lfsr_q, 16'h8000);
    check_val("mid_reset_freq0", dut.freq_q[0], 16'd0);
    check_val("mid_reset_atten0", 16'(dut.atten_q[0]), 16'hF);
    @(negedge clk);
    reset = 1'b0;
    wait_clks(600);
    check_val("post_reset_sample", sample, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
